// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, drives the instruction memory address and fills the
// IF/ID register, honouring redirects, stalls, flushes and a HALT opcode.
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] inst_add,
    input  logic [31:0] inst,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic        state_dbg
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

    state_t      state, state_nxt;
    ifid_op_t    ifid_op;
    logic [31:0] pc, pc_nxt, pc_plus1;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        halt_op;

    // inst_add comes straight from the PC register, so no control input can
    // reach the memory address combinationally.
    assign inst_add  = pc;
    assign pc_plus1  = pc + 32'd1;
    assign halt_op   = (inst[31:26] == HALT_OPCODE);
    assign redirect  = branch_taken | jump;
    // Branch belongs to the older instruction, so it wins over a jump.
    assign redirect_target = branch_taken ? branch_target : jump_target;

    assign halted    = (state == HALTED);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // if_id_valid qualifies the IF/ID payload: decode consumes it only when
    // high; there is no back-pressure other than stall.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ifid_op   = IFID_HOLD;
        if (redirect) begin
            pc_nxt    = redirect_target;
            state_nxt = RUN;
            ifid_op   = IFID_BUBBLE;
        end else if (stall) begin
            ifid_op = flush ? IFID_BUBBLE : IFID_HOLD;
        end else if (state == HALTED) begin
            ifid_op = IFID_BUBBLE;
        end else if (halt_op) begin
            state_nxt = HALTED;
            ifid_op   = IFID_BUBBLE;
        end else begin
            pc_nxt  = pc_plus1;
            ifid_op = flush ? IFID_BUBBLE : IFID_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_inst     <= 32'd0;
            if_id_pc_plus1 <= 32'd0;
            if_id_valid    <= 1'b0;
            fetch_count    <= 32'd0;
        end else begin
            case (ifid_op)
                IFID_LOAD: begin
                    if_id_inst     <= inst;
                    if_id_pc_plus1 <= pc_plus1;
                    if_id_valid    <= 1'b1;
                    fetch_count    <= fetch_count + 32'd1;
                end
                IFID_BUBBLE: begin
                    if_id_inst     <= 32'd0;
                    if_id_pc_plus1 <= 32'd0;
                    if_id_valid    <= 1'b0;
                end
                default: begin
                    if_id_inst     <= if_id_inst;
                    if_id_pc_plus1 <= if_id_pc_plus1;
                    if_id_valid    <= if_id_valid;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios plus a random phase,
// with a per-edge expected queue fed by a reference model of the fetch rules.
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst, stall, flush, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] inst_add, inst;
    logic [31:0] if_id_inst, if_id_pc_plus1, fetch_count;
    logic        if_id_valid, halted, state_dbg;

    logic [31:0] mem [0:255];
    int          n_checks;
    int          n_fail;

    // expected entry: inst_add, if_id_inst, pc_plus1, count, valid, halted
    logic [129:0] exp_q[$];

    logic [31:0] m_pc, m_inst, m_pp1, m_cnt;
    logic        m_valid, m_halted;

    localparam logic [31:0] HALT_WORD = 32'hFC00_0123;
    localparam logic [31:0] W_A = 32'h0400_00AA;
    localparam logic [31:0] W_B = 32'h0800_00BB;
    localparam logic [31:0] W_C = 32'h0C00_00CC;
    localparam logic [31:0] W_D = 32'h1000_00DD;

    instruction_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .inst_add       (inst_add),
        .inst           (inst),
        .if_id_inst     (if_id_inst),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count),
        .state_dbg      (state_dbg)
    );

    assign inst = mem[inst_add[7:0]];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // reference model: next values of the model registers for one edge
    task automatic model_edge(input logic r, input logic st, input logic fl,
                              input logic br, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt);
        logic [31:0] w;
        logic        is_halt;
        logic [31:0] npc;
        w       = mem[m_pc[7:0]];
        is_halt = (w[31:26] == 6'b111111);
        if (r) begin
            m_pc = 32'd0; m_inst = 32'd0; m_pp1 = 32'd0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 32'd0;
        end else begin
            if (br)                  npc = bt;
            else if (j)              npc = jt;
            else if (st)             npc = m_pc;
            else if (m_halted)       npc = m_pc;
            else if (is_halt)        npc = m_pc;
            else                     npc = m_pc + 32'd1;

            if (fl || br || j) begin
                m_inst = 32'd0; m_pp1 = 32'd0; m_valid = 1'b0;
            end else if (st) begin
                // hold
            end else if (m_halted || is_halt) begin
                m_inst = 32'd0; m_pp1 = 32'd0; m_valid = 1'b0;
            end else begin
                m_inst = w; m_pp1 = m_pc + 32'd1; m_valid = 1'b1;
                m_cnt  = m_cnt + 32'd1;
            end

            if (br || j)                          m_halted = 1'b0;
            else if (!st && !m_halted && is_halt) m_halted = 1'b1;
            m_pc = npc;
        end
    endtask

    // driver: apply one cycle of inputs, push expectation, compare after edge
    task automatic step(input logic r, input logic st, input logic fl,
                        input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
        logic [129:0] e;
        @(negedge clk);
        rst = r; stall = st; flush = fl;
        branch_taken = br; branch_target = bt; jump = j; jump_target = jt;
        model_edge(r, st, fl, br, bt, j, jt);
        exp_q.push_back({m_pc, m_inst, m_pp1, m_cnt, m_valid, m_halted});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("inst_add",       inst_add,                 e[129:98]);
        check("if_id_inst",     if_id_inst,               e[97:66]);
        check("if_id_pc_plus1", if_id_pc_plus1,           e[65:34]);
        check("fetch_count",    fetch_count,              e[33:2]);
        check("if_id_valid",    {31'd0, if_id_valid},     {31'd0, e[1]});
        check("halted",         {31'd0, halted},          {31'd0, e[0]});
        check("state_dbg",      {31'd0, state_dbg},       {31'd0, e[0]});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'd0; jump = 1'b0; jump_target = 32'd0;
        m_pc = 32'd0; m_inst = 32'd0; m_pp1 = 32'd0; m_cnt = 32'd0;
        m_valid = 1'b0; m_halted = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {6'(i % 62), 26'($urandom)};
        mem[0] = W_A; mem[1] = W_B; mem[2] = W_C; mem[3] = W_D;
        mem[5] = HALT_WORD;

        // reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("rst_inst_add", inst_add, 32'd0);
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_count", fetch_count, 32'd0);

        // free run
        run(1);
        check("run_a", if_id_inst, W_A);
        check("run_a_pp1", if_id_pc_plus1, 32'd1);
        run(1);
        check("run_b", if_id_inst, W_B);
        check("run_pc2", inst_add, 32'd2);

        // stall two cycles at PC=2
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("stall_pc", inst_add, 32'd2);
        check("stall_pp1", if_id_pc_plus1, 32'd2);
        check("stall_count", fetch_count, 32'd2);
        run(1);
        check("resume_c", if_id_inst, W_C);
        check("resume_pc", inst_add, 32'd3);
        check("resume_count", fetch_count, 32'd3);

        // run into HALT at mem[5]
        run(3);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", inst_add, 32'd5);
        run(2);
        check("halt_hold_pc", inst_add, 32'd5);
        check("halt_valid", {31'd0, if_id_valid}, 32'd0);

        // jump out of HALTED
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        check("unhalt_flag", {31'd0, halted}, 32'd0);
        check("unhalt_pc", inst_add, 32'd0);
        run(1);
        check("unhalt_a", if_id_inst, W_A);

        // branch and jump together: branch wins, one bubble
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'd10, 1'b1, 32'd20);
        check("br_pc", inst_add, 32'd10);
        check("br_bubble", {31'd0, if_id_valid}, 32'd0);
        run(1);
        check("br_inst", if_id_inst, mem[10]);
        check("br_pp1", if_id_pc_plus1, 32'd11);

        // flush with stall
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check("flush_valid", {31'd0, if_id_valid}, 32'd0);
        check("flush_inst", if_id_inst, 32'd0);
        check("flush_pc", inst_add, 32'd11);

        // PC wrap at 0xFFFFFFFF
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0);
        run(1);
        check("wrap_pc", inst_add, 32'd0);
        check("wrap_pp1", if_id_pc_plus1, 32'd0);

        // reset mid-stream at PC=7
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'd6);
        run(1);
        check("pre_rst_pc", inst_add, 32'd7);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        check("mid_rst_pc", inst_add, 32'd0);
        check("mid_rst_count", fetch_count, 32'd0);
        check("mid_rst_inst", if_id_inst, 32'd0);

        // random phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 12)),
                 $urandom_range(0, 9) == 0, 32'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage that drives the instruction memory address and captures the returned word into the IF/ID pipeline register. It owns the program counter, applies branch/jump redirects, stalls and flushes from downstream hazard logic, and detects a HALT opcode to stop fetching. It sits between the hazard/branch-resolution logic and the decode stage, with the combinational instruction memory hanging off `inst_add`/`inst`.

## Interface
Parameters:
- `RESET_PC`, 32'd0, PC value loaded on reset (word address).
- `HALT_OPCODE`, 6'b111111, opcode field value `inst[31:26]` that halts fetch.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold PC and IF/ID contents.
- `flush`  in  1  write a bubble into IF/ID this edge.
- `branch_taken`  in  1  redirect PC to `branch_target`.
- `branch_target`  in  32  absolute word address.
- `jump`  in  1  redirect PC to `jump_target`.
- `jump_target`  in  32  absolute word address.
- `inst_add`  out  32  instruction memory address (= PC, combinational from PC register).
- `inst`  in  32  instruction word from memory, valid same cycle as `inst_add`.
- `if_id_inst`  out  32  registered instruction to decode.
- `if_id_pc_plus1`  out  32  registered PC+1 of that instruction.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch stopped by HALT.
- `fetch_count`  out  32  number of valid instructions written into IF/ID.

## Operation
- Word addressing: PC advances by 1 per instruction; memory indexes with `inst_add[7:0]`. PC arithmetic is 32-bit modulo 2^32 (0xFFFFFFFF + 1 = 0).
- States: RUN, HALTED.
- Next-PC priority (highest first): `rst` -> RESET_PC; `branch_taken` -> `branch_target`; `jump` -> `jump_target`; `stall` -> hold; HALTED -> hold; HALT opcode fetched in RUN -> hold; else PC+1.
- `branch_taken` and `jump` together: branch wins (older instruction).
- IF/ID priority: `rst` -> zeros, valid 0; `flush` or redirect -> bubble (inst 0, pc_plus1 0, valid 0); `stall` -> hold; HALTED -> bubble; HALT opcode in RUN -> bubble; else load `inst`, PC+1, valid 1.
- `flush` beats `stall` on IF/ID; PC still holds under stall unless redirected.
- RUN -> HALTED: in RUN, no stall, no redirect, `inst[31:26] == HALT_OPCODE`. HALT word is not forwarded; PC stays at HALT address.
- HALTED -> RUN: `branch_taken` or `jump` (HALT was speculative); PC loads target. Only `rst` or redirect leaves HALTED.
- `fetch_count` increments by 1 on every edge that loads IF/ID with valid 1; wraps modulo 2^32; frozen otherwise.

## Timing
- Reset values: PC=RESET_PC (so `inst_add`=RESET_PC), `if_id_inst`=0, `if_id_pc_plus1`=0, `if_id_valid`=0, `halted`=0, `fetch_count`=0, state RUN.
- `rst` asserted mid-operation overrides every other input on that edge.
- Latency: instruction at PC=N appears on `if_id_inst` one edge after `inst_add`=N, with `if_id_pc_plus1`=N+1.
- Redirect: target on `inst_add` the cycle after the redirect edge; first target instruction valid in IF/ID one edge later; exactly one bubble inserted.
- `halted` asserts the edge after the HALT word is on `inst`; deasserts on the redirect edge.
- No combinational path from `stall`/`flush`/redirect inputs to `inst_add`.

## Test plan
- Reset then free-run with mem[0..3] = A,B,C,D -> `inst_add` 0,1,2,3; `if_id_inst` A,B,C on cycles 1..3, `if_id_pc_plus1` 1,2,3, `fetch_count`=3 after 3 edges.
- Stall 2 cycles while PC=2 -> `inst_add` stays 2, IF/ID holds PC+1=2 word, `fetch_count` frozen; resumes at 3 after release.
- `branch_taken`=1, `branch_target`=10 with `jump`=1, `jump_target`=20 same cycle -> next `inst_add`=10, one bubble (valid 0), then mem[10] valid with pc_plus1=11.
- HALT word (opcode 6'b111111) at mem[5] -> `halted`=1, `inst_add` frozen at 5, IF/ID valid 0 thereafter; `jump` to 0 -> `halted`=0, fetch restarts at 0.
- `flush`=1 and `stall`=1 together -> IF/ID valid 0, inst 0; PC unchanged.
- `rst` pulsed while PC=7 and halted=0 mid-stream -> next edge all outputs at reset values, `inst_add`=RESET_PC.
